// File: rtl/serial_rxtx_core_if.sv
// serial_rxtx_core_if: receiver strobe/byte and transmitter start/busy/byte handshake bundle
interface serial_rxtx_core_if;
  logic       RxD_data_ready;
  logic [7:0] RxD_data;
  logic       TxD_busy;
  logic       TxD_start;
  logic [7:0] TxD_data;
  modport master (input RxD_data_ready, RxD_data, TxD_busy, output TxD_start, TxD_data);
  modport slave (output RxD_data_ready, RxD_data, TxD_busy, input TxD_start, TxD_data);
endinterface

// File: rtl/serial_rxtx_core.sv
// serial_rxtx_core: FIFO-buffered byte echo with increment, LED shift register and overflow flag; SERIAL_RXTX_OVF_NOTIFY_EN adds a '!' notify frame after drops
module serial_rxtx_core #(
  parameter int         NumberOfLEDs  = 2,
  parameter int         FifoDepthLog2 = 4,
  parameter logic [7:0] Increment     = 8'd1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_rxtx_core_if.master       bus,
  output logic [NumberOfLEDs-1:0]  LED,
  output logic [FifoDepthLog2:0]   fifo_level,
  output logic                     overflow
);
  localparam int Depth = 1 << FifoDepthLog2;
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t                   state;
  logic [7:0]               mem [Depth];
  logic [FifoDepthLog2-1:0] wr_ptr, rd_ptr;
  logic                     notify, full, pop, push, drop;
  logic [NumberOfLEDs+7:0]  led_shift;
  // a full FIFO still accepts a byte when the head leaves in the same cycle
  always_comb begin
    full      = fifo_level[FifoDepthLog2];
    pop       = state == IDLE && fifo_level != '0 && !notify;
    push      = bus.RxD_data_ready && (!full || pop);
    drop      = bus.RxD_data_ready && full && !pop;
    led_shift = {LED, bus.RxD_data};
  end
`ifdef SERIAL_RXTX_OVF_NOTIFY_EN
  // pending notify: any number of drops collapse into one, consumed when IDLE launches it
  always_ff @(posedge clk)
    if (!rst_n) notify <= 1'b0;
    else if (drop) notify <= 1'b1;
    else if (state == IDLE) notify <= 1'b0;
`else
  assign notify = 1'b0;
`endif
  // storage only; contents are meaningless after reset because the pointers restart
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.RxD_data;
  // pointers, occupancy, LED, overflow and the transmit FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.TxD_start <= 1'b0;
      bus.TxD_data  <= 8'h00;
      LED           <= '0;
      fifo_level    <= '0;
      overflow      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      if (bus.RxD_data_ready) LED <= led_shift[NumberOfLEDs-1:0];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) fifo_level <= push ? fifo_level + 1'b1 : fifo_level - 1'b1;
      if (drop) overflow <= 1'b1;
      bus.TxD_start <= 1'b0;
      case (state)
        IDLE:
          if (notify || pop) begin
            bus.TxD_data  <= notify ? 8'h21 : mem[rd_ptr] + Increment;
            bus.TxD_start <= 1'b1;
            state         <= START;
          end
        START:     state <= WAIT_BUSY;
        WAIT_BUSY: if (bus.TxD_busy) state <= WAIT_DONE;
        WAIT_DONE: if (!bus.TxD_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_rxtx_core.sv
// tb_serial_rxtx_core: vector table plus directed and randomized scoreboard checks on two configurations
module tb_serial_rxtx_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b;
  serial_rxtx_core_if ifa();
  serial_rxtx_core_if ifb();
  logic [1:0]  led_a;
  logic [4:0]  lvl_a;
  logic        ovf_a;
  logic [11:0] led_b;
  logic [2:0]  lvl_b;
  logic        ovf_b;
  serial_rxtx_core #(.NumberOfLEDs(2), .FifoDepthLog2(4), .Increment(8'h01)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(ifa), .LED(led_a), .fifo_level(lvl_a), .overflow(ovf_a));
  serial_rxtx_core #(.NumberOfLEDs(12), .FifoDepthLog2(2), .Increment(8'h10)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(ifb), .LED(led_b), .fifo_level(lvl_b), .overflow(ovf_b));

  int n_checks = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] got_a[$], got_b[$];
  int blen_a = 3, blen_b = 3, peak_a = 0;
  always @(negedge clk) if (ifa.TxD_start === 1'b1) got_a.push_back(ifa.TxD_data);
  always @(negedge clk) if (ifb.TxD_start === 1'b1) got_b.push_back(ifb.TxD_data);
  always @(negedge clk) if (int'(lvl_a) > peak_a) peak_a = int'(lvl_a);

  // transmitter models: busy from the cycle after start for blen cycles
  initial begin
    ifa.TxD_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.TxD_start === 1'b1) begin
        @(negedge clk);
        ifa.TxD_busy = 1'b1;
        repeat (blen_a) @(negedge clk);
        ifa.TxD_busy = 1'b0;
      end
    end
  end
  initial begin
    ifb.TxD_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ifb.TxD_start === 1'b1) begin
        @(negedge clk);
        ifb.TxD_busy = 1'b1;
        repeat (blen_b) @(negedge clk);
        ifb.TxD_busy = 1'b0;
      end
    end
  end

  task automatic burst_a(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifa.RxD_data = first + 8'(i);
      ifa.RxD_data_ready = 1'b1;
    end
    @(negedge clk);
    ifa.RxD_data_ready = 1'b0;
  endtask
  task automatic burst_b(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ifb.RxD_data = first + 8'(i);
      ifb.RxD_data_ready = 1'b1;
    end
    @(negedge clk);
    ifb.RxD_data_ready = 1'b0;
  endtask
  task automatic wait_a(input int n, input int limit, input string name);
    int k = 0;
    while (got_a.size() < n && k < limit) begin @(negedge clk); k++; end
    check(name, got_a.size(), n);
  endtask
  task automatic wait_b(input int n, input int limit, input string name);
    int k = 0;
    while (got_b.size() < n && k < limit) begin @(negedge clk); k++; end
    check(name, got_b.size(), n);
  endtask

  typedef struct { logic [7:0] rx; logic [7:0] tx; logic [1:0] led; } vec_t;
  vec_t tbl[6];
  logic [7:0] exp_q[$];

  initial begin
    int base, k, n;
    logic [7:0] b;
    tbl[0] = '{8'h41, 8'h42, 2'b01};
    tbl[1] = '{8'hFF, 8'h00, 2'b11};
    tbl[2] = '{8'h00, 8'h01, 2'b00};
    tbl[3] = '{8'h7E, 8'h7F, 2'b10};
    tbl[4] = '{8'h80, 8'h81, 2'b00};
    tbl[5] = '{8'h55, 8'h56, 2'b01};
    ifa.RxD_data_ready = 1'b0; ifa.RxD_data = 8'h00;
    ifb.RxD_data_ready = 1'b0; ifb.RxD_data = 8'h00;
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    check("rst_a_start", ifa.TxD_start, 0);
    check("rst_a_data", ifa.TxD_data, 0);
    check("rst_a_led", led_a, 0);
    check("rst_a_level", lvl_a, 0);
    check("rst_a_ovf", ovf_a, 0);
    check("rst_b_led", led_b, 0);
    check("rst_b_level", lvl_b, 0);
    check("rst_b_ovf", ovf_b, 0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ifa.RxD_data = tbl[i].rx;
      ifa.RxD_data_ready = 1'b1;
      k = 0;
      do begin @(negedge clk); ifa.RxD_data_ready = 1'b0; k++; end
      while (ifa.TxD_start !== 1'b1 && k < 20);
      check($sformatf("vec%0d_latency", i), k, 2);
      check($sformatf("vec%0d_tx", i), ifa.TxD_data, tbl[i].tx);
      check($sformatf("vec%0d_led", i), led_a, tbl[i].led);
      check($sformatf("vec%0d_ovf", i), ovf_a, 0);
      repeat (blen_a + 6) @(negedge clk);
    end

    blen_a = 100;
    peak_a = 0;
    base = got_a.size();
    burst_a(8'h00, 5);
    wait_a(base + 5, 1000, "burst_count");
    for (int i = 0; i < 5 && base + i < got_a.size(); i++)
      check($sformatf("burst_tx%0d", i), got_a[base+i], i + 1);
    check("burst_peak", peak_a, 4);
    check("burst_ovf", ovf_a, 0);
    repeat (110) @(negedge clk);

    blen_a = 60;
    burst_a(8'h60, 4);
    repeat (10) @(negedge clk);
    check("midframe_level", lvl_a, 3);
    check("midframe_busy", ifa.TxD_busy, 1);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    check("midrst_start", ifa.TxD_start, 0);
    check("midrst_data", ifa.TxD_data, 0);
    check("midrst_led", led_a, 0);
    check("midrst_level", lvl_a, 0);
    check("midrst_ovf", ovf_a, 0);
    n = got_a.size();
    repeat (200) @(negedge clk);
    check("midrst_no_tx", got_a.size(), n);

    base = got_b.size();
    burst_b(8'hF8, 1);
    wait_b(base + 1, 100, "wrap_inc_count");
    if (got_b.size() > base) check("wrap_inc_tx", got_b[base], 8'h08);
    burst_b(8'hAB, 1);
    burst_b(8'hCD, 1);
    wait_b(base + 3, 200, "led12_count");
    check("led12", led_b, 12'hBCD);
    if (got_b.size() > base + 2) begin
      check("led12_tx0", got_b[base+1], 8'hBB);
      check("led12_tx1", got_b[base+2], 8'hDD);
    end
    repeat (20) @(negedge clk);

    blen_b = 100;
    base = got_b.size();
    burst_b(8'h30, 6);
    check("ovf_level", lvl_b, 4);
    check("ovf_flag", ovf_b, 1);
    check("ovf_led", led_b, 12'h435);
`ifdef SERIAL_RXTX_OVF_NOTIFY_EN
    exp_q = '{8'h40, 8'h21, 8'h41, 8'h42, 8'h43, 8'h44};
`else
    exp_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
`endif
    wait_b(base + exp_q.size(), 2000, "ovf_count");
    for (int i = 0; i < exp_q.size() && base + i < got_b.size(); i++)
      check($sformatf("ovf_tx%0d", i), got_b[base+i], exp_q[i]);
    repeat (110) @(negedge clk);
    check("ovf_drained", lvl_b, 0);
    check("ovf_sticky", ovf_b, 1);

    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    check("rst_b_clears_ovf", ovf_b, 0);
    exp_q.delete();
    base = got_b.size();
    for (int i = 0; i < 40; i++) begin
      k = 0;
      while (exp_q.size() - (got_b.size() - base) >= 4 && k < 500) begin @(negedge clk); k++; end
      if (k >= 500) begin
        check("rand_stall", k, 0);
        break;
      end
      b = 8'($urandom);
      blen_b = $urandom_range(1, 8);
      burst_b(b, 1);
      exp_q.push_back(b + 8'h10);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_b(base + exp_q.size(), 3000, "rand_count");
    for (int i = 0; i < exp_q.size() && base + i < got_b.size(); i++)
      check($sformatf("rand_tx%0d", i), got_b[base+i], exp_q[i]);
    check("rand_ovf", ovf_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
